// File: rtl/bin_gray_serial_5bit.sv
// Serial binary-to-Gray converter: parallel word in, MSB-first
// Gray bitstream out, and the reassembled Gray word on a handshake.
module bin_gray_serial_5bit #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nx;
  logic             hist;
  logic             hist_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-2:0] gray_sr;
  logic [WIDTH-2:0] gray_sr_nx;
  logic [WIDTH-1:0] gray_nx;
  logic             sout_nx;
  logic             sval_nx;
  logic             oval_nx;
  logic             bit_b;
  logic             bit_g;
  logic [WIDTH-1:0] gray_full;

  assign in_ready = (state == IDLE);

  // State and datapath registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      hist      <= 1'b0;
      cnt       <= '0;
      gray_sr   <= '0;
      gray_out  <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      sreg      <= sreg_nx;
      hist      <= hist_nx;
      cnt       <= cnt_nx;
      gray_sr   <= gray_sr_nx;
      gray_out  <= gray_nx;
      ser_out   <= sout_nx;
      ser_valid <= sval_nx;
      out_valid <= oval_nx;
    end
  end

  // Next-state logic: one Gray bit per SHIFT cycle from the
  // current binary bit XOR the previous binary bit (hist).
  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    hist_nx    = hist;
    cnt_nx     = cnt;
    gray_sr_nx = gray_sr;
    gray_nx    = gray_out;
    sout_nx    = ser_out;
    sval_nx    = ser_valid;
    oval_nx    = out_valid;
    bit_b      = sreg[WIDTH-1];
    bit_g      = bit_b ^ hist;
    gray_full  = {gray_sr, bit_g};
    unique case (state)
      IDLE: begin
        sval_nx = 1'b0;
        if (in_valid) begin
          sreg_nx  = bin_in;
          hist_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        hist_nx    = bit_b;
        sout_nx    = bit_g;
        sval_nx    = 1'b1;
        gray_sr_nx = gray_full[WIDTH-2:0];
        sreg_nx    = sreg << 1;
        cnt_nx     = cnt + CW'(1);
        if (cnt == LAST) begin
          gray_nx  = gray_full;
          oval_nx  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        sval_nx = 1'b0;
        if (out_ready) begin
          oval_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
